// File: rtl/dcache_mem_stage_if.sv
// Line-level handshake between the L1 data cache and off-chip data memory.
// The master drives requests and write-back data; the slave returns fetched lines with an ack.
interface dcache_mem_stage_if #(
  parameter int unsigned LINE_BITS = 256
);
  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [31:0]          mem_addr_o;
  logic [LINE_BITS-1:0] mem_wdata_o;
  logic [LINE_BITS-1:0] mem_rdata_i;
  logic                 mem_ack_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    input  mem_rdata_i,
    input  mem_ack_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    output mem_rdata_i,
    output mem_ack_i
  );
endinterface

// File: rtl/dcache_mem_stage.sv
// Direct-mapped, write-back, write-allocate L1 data cache for the MEM stage.
// Misses stall the pipeline while a line is written back and/or fetched over the memory interface.
module dcache_mem_stage #(
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned LINE_BITS = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                memRead_i,
  input  logic                memWrite_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         wdata_i,
  output logic [31:0]         rdata_o,
  output logic                stall_o,
  dcache_mem_stage_if.master  mem
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 32 - 5 - IDX_W;

  typedef enum logic [1:0] {StIdle, StWb, StAlloc, StFill} state_e;

  state_e                 state_q;
  logic [NUM_LINES-1:0]   valid_q;
  logic [NUM_LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0]   data_q [NUM_LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [2:0]       wordSel;
  logic             req;
  logic             hit;
  logic             storeHit;
  logic             fillWe;
  logic [31:0]      victimAddr;
  logic [31:0]      fillAddr;
  logic [1:0]       unusedAddr;

  assign idx        = addr_i[5+IDX_W-1:5];
  assign tag        = addr_i[31:5+IDX_W];
  assign wordSel    = addr_i[4:2];
  assign unusedAddr = addr_i[1:0];

  // A request with both strobes set is a store.
  assign req      = memRead_i | memWrite_i;
  assign hit      = req & valid_q[idx] & (tag_q[idx] == tag) & (state_q == StIdle);
  assign storeHit = hit & memWrite_i;
  assign fillWe   = (state_q == StAlloc) & mem.mem_ack_i;

  assign victimAddr = {tag_q[idx], idx, 5'b0};
  assign fillAddr   = {tag, idx, 5'b0};

  assign stall_o = (req & ~hit) | (state_q != StIdle);

  always_comb begin
    rdata_o = 32'b0;
    if (memRead_i && !memWrite_i && hit) begin
      rdata_o = data_q[idx][{wordSel, 5'b0} +: 32];
    end
  end

  // Tag and data arrays carry no reset; validity alone guards them.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (fillWe) begin
        data_q[idx] <= mem.mem_rdata_i;
        tag_q[idx]  <= tag;
      end else if (storeHit) begin
        data_q[idx][{wordSel, 5'b0} +: 32] <= wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      valid_q         <= '0;
      dirty_q         <= '0;
      mem.mem_req_o   <= 1'b0;
      mem.mem_we_o    <= 1'b0;
      mem.mem_addr_o  <= '0;
      mem.mem_wdata_o <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req && !hit) begin
            mem.mem_req_o <= 1'b1;
            if (valid_q[idx] && dirty_q[idx]) begin
              state_q         <= StWb;
              mem.mem_we_o    <= 1'b1;
              mem.mem_addr_o  <= victimAddr;
              mem.mem_wdata_o <= data_q[idx];
            end else begin
              state_q        <= StAlloc;
              mem.mem_we_o   <= 1'b0;
              mem.mem_addr_o <= fillAddr;
            end
          end else if (storeHit) begin
            dirty_q[idx] <= 1'b1;
          end
        end
        StWb: begin
          // Request stays high straight into the fetch phase.
          if (mem.mem_ack_i) begin
            state_q        <= StAlloc;
            mem.mem_we_o   <= 1'b0;
            mem.mem_addr_o <= fillAddr;
          end
        end
        StAlloc: begin
          if (mem.mem_ack_i) begin
            state_q       <= StFill;
            mem.mem_req_o <= 1'b0;
            valid_q[idx]  <= 1'b1;
            dirty_q[idx]  <= 1'b0;
          end
        end
        StFill: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_mem_stage.sv
// Self-checking bench for dcache_mem_stage: directed steps then random traffic against an
// architectural memory model with a per-index residency/dirty tracker.
module tb_dcache_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned fails = 0;

  dcache_mem_stage_if #(.LINE_BITS(256)) mif ();

  dcache_mem_stage #(
    .NUM_LINES(32),
    .LINE_BITS(256)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .memRead_i (memRead),
    .memWrite_i(memWrite),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .stall_o   (stall),
    .mem       (mif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Architectural view (what a load must return) and off-chip memory contents, keyed by word address.
  logic [31:0] archMem [int unsigned];
  logic [31:0] bkMem   [int unsigned];
  bit          modValid [32];
  bit          modDirty [32];
  int unsigned modTag   [32];

  function automatic logic [31:0] bgWord(int unsigned wa);
    if ((wa >> 3) == 2) return 32'(wa & 7) + 32'd1;
    return (wa * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] rdArch(int unsigned wa);
    if (archMem.exists(wa)) return archMem[wa];
    return bgWord(wa);
  endfunction

  function automatic logic [31:0] rdBk(int unsigned wa);
    if (bkMem.exists(wa)) return bkMem[wa];
    return bgWord(wa);
  endfunction

  function automatic logic [255:0] archLine(int unsigned la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = rdArch((la >> 2) + i);
    return l;
  endfunction

  function automatic logic [255:0] bkLine(int unsigned la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = rdBk((la >> 2) + i);
    return l;
  endfunction

  logic [255:0] lastWbData;

  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input int wbD, input int fD);
    int unsigned idx, tg, la, victimLa;
    bit          hit, dv;
    int          expStall, expHigh, expTx, stalls, highCycles, phaseCnt, nTx, k;
    logic [31:0] expR, gotR;
    logic [31:0] txAddr [2];
    logic        txWe   [2];
    logic [255:0] txData [2];
    logic [255:0] expWb;

    idx      = (a >> 5) & 31;
    tg       = a >> 10;
    la       = a & ~32'd31;
    hit      = modValid[idx] && (modTag[idx] == tg);
    dv       = !hit && modValid[idx] && modDirty[idx];
    victimLa = (modTag[idx] << 10) | (idx << 5);
    expWb    = archLine(victimLa);
    expStall = hit ? 0 : 2 + fD + (dv ? wbD : 0);
    expHigh  = hit ? 0 : fD + (dv ? wbD : 0);
    expTx    = hit ? 0 : (dv ? 2 : 1);
    for (int i = 0; i < 2; i++) begin
      txAddr[i] = '1;
      txWe[i]   = 1'bx;
      txData[i] = '1;
    end

    memRead = rd; memWrite = wr; addr = a; wdata = wd;
    #1;
    stalls = 0; highCycles = 0; phaseCnt = 0; nTx = 0;
    while (stall && stalls < 200) begin
      stalls++;
      if (mif.mem_req_o) begin
        highCycles++;
        phaseCnt++;
        if (phaseCnt == (mif.mem_we_o ? wbD : fD)) begin
          if (nTx < 2) begin
            txAddr[nTx] = mif.mem_addr_o;
            txWe[nTx]   = mif.mem_we_o;
            txData[nTx] = mif.mem_wdata_o;
          end
          nTx++;
          if (mif.mem_we_o) begin
            for (int i = 0; i < 8; i++) bkMem[(mif.mem_addr_o >> 2) + i] = mif.mem_wdata_o[i*32 +: 32];
          end else begin
            mif.mem_rdata_i = bkLine(mif.mem_addr_o);
          end
          mif.mem_ack_i = 1'b1;
          phaseCnt = 0;
        end
      end
      @(negedge clk);
      mif.mem_ack_i   = 1'b0;
      mif.mem_rdata_i = {8{$urandom}};
      #1;
    end
    gotR = rdata;

    if (!hit) begin
      modValid[idx] = 1'b1;
      modTag[idx]   = tg;
      modDirty[idx] = 1'b0;
    end
    if (wr) begin
      expR = 32'h0;
      archMem[a >> 2] = wd;
      modDirty[idx] = 1'b1;
    end else begin
      expR = rdArch(a >> 2);
    end

    chk("stall_cycles", stalls, expStall);
    chk("req_high_cycles", highCycles, expHigh);
    chk("txn_count", nTx, expTx);
    chk("rdata", gotR, expR);
    chk("req_low_on_hit", mif.mem_req_o, 1'b0);
    if (dv) begin
      chk("wb_we", txWe[0], 1'b1);
      chk("wb_addr", txAddr[0], victimLa);
      chk("wb_data", txData[0], expWb);
    end
    if (!hit) begin
      k = dv ? 1 : 0;
      chk("fetch_we", txWe[k], 1'b0);
      chk("fetch_addr", txAddr[k], la);
    end
    lastWbData = txData[0];
    @(negedge clk);
  endtask

  initial begin
    bit rd, wr;
    logic [31:0] a;
    int op;

    mif.mem_ack_i   = 1'b0;
    mif.mem_rdata_i = '0;
    for (int i = 0; i < 32; i++) begin
      modValid[i] = 1'b0; modDirty[i] = 1'b0; modTag[i] = 0;
    end

    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_req", mif.mem_req_o, 1'b0);
    chk("rst_we", mif.mem_we_o, 1'b0);
    chk("rst_addr", mif.mem_addr_o, 32'h0);
    chk("rst_wdata", mif.mem_wdata_o, 256'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed steps from the test plan.
    access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 3);
    access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1, 1);
    access(1'b0, 1'b1, 32'h0000_0048, 32'hDEAD_BEEF, 1, 1);
    access(1'b1, 1'b0, 32'h0000_0048, 32'h0, 1, 1);
    access(1'b1, 1'b0, 32'h0000_0440, 32'h0, 2, 3);
    chk("wb_word2", lastWbData[95:64], 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'h0000_0444, 32'h0, 1, 1);
    access(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 1, 2);
    access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 1);

    // Random traffic over a few indices and tags to force hits, clean and dirty evictions.
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 4);
      rd = (op <= 1) || (op == 4);
      wr = (op == 2) || (op == 3) || (op == 4);
      a  = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5) |
           ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      access(rd, wr, a, $urandom, $urandom_range(1, 4), $urandom_range(1, 4));
    end

    // Reset while a fetch is outstanding.
    memRead = 1'b1; memWrite = 1'b0; addr = 32'h0000_0080;
    #1;
    chk("abort_detect_stall", stall, 1'b1);
    @(negedge clk); #1;
    chk("abort_req_up", mif.mem_req_o, 1'b1);
    chk("abort_fetch_addr", mif.mem_addr_o, 32'h0000_0080);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("abort_req_dropped", mif.mem_req_o, 1'b0);
    chk("abort_stall_after_rst", stall, 1'b1);
    rst = 1'b0; memRead = 1'b0;
    #1;
    chk("abort_idle_stall", stall, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      modValid[i] = 1'b0; modDirty[i] = 1'b0;
    end
    archMem = bkMem;

    access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 2);
    access(1'b1, 1'b0, 32'h0000_0080, 32'h0, 1, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
